// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the iterative multiply/divide unit.
// Holds op encodings, FSM state enumeration, iteration count, the
// divide-by-zero quotient and an operand magnitude helper.
package muldiv_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = 6;

  localparam logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Absolute value for signed ops; 32'h80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x,
                                            input logic is_signed);
    return (is_signed && x[DATA_W-1]) ? DATA_W'(-x) : x;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: one-bit-per-cycle iteration datapath.
// Multiply: radix-2 shift-add, {hi, lo} holds the product after 32 steps.
// Divide (only with MULDIV_DIV_EN): restoring shift-subtract, hi = remainder,
// lo = quotient after 32 steps.
// Ports: clk, rst (async high), load (init from mag_a/mag_b), step (one
//        iteration), is_div, mag_a, mag_b, hi, lo.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] mag_a,
  input  logic [DATA_W-1:0] mag_b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] dvsr;
  logic [DATA_W:0]   add_sum;

  assign hi = acc;
  assign lo = sr;

  // Multiply step: conditionally add the multiplicand, then shift {carry,acc,sr} right.
  always_comb begin
    add_sum = {1'b0, acc} + (sr[0] ? {1'b0, dvsr} : '0);
  end

`ifdef MULDIV_DIV_EN
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              fits;

  // Divide step: shift the next dividend bit into the partial remainder and
  // subtract when it fits; the 32-bit difference is exact whenever fits=1.
  always_comb begin
    shifted = {acc, sr[DATA_W-1]};
    fits    = (shifted >= {1'b0, dvsr});
    diff    = shifted[DATA_W-1:0] - dvsr;
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      sr   <= '0;
      dvsr <= '0;
    end else if (load) begin
      acc  <= '0;
      sr   <= mag_a;
      dvsr <= mag_b;
    end else if (step) begin
`ifdef MULDIV_DIV_EN
      if (is_div) begin
        acc <= fits ? diff : shifted[DATA_W-1:0];
        sr  <= {sr[DATA_W-2:0], fits};
      end else
`endif
      begin
        acc <= add_sum[DATA_W:1];
        sr  <= {add_sum[0], sr[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with fixed 35-cycle latency.
// Accept edge E0 -> PREP -> 32x CALC -> FIX -> DONE (multWe high E34..E35).
// Macro MULDIV_DIV_EN compiles the divider in; without it DIV/DIVU starts
// are ignored.
// Ports: clk, rst (async high), start, op, a, b, cancel (flush),
//        busy, multWe (HI/LO write strobe), busmult ({HI, LO}).
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                cancel,
  output logic                busy,
  output logic                multWe,
  output logic [2*DATA_W-1:0] busmult
);

  state_e              state;
  op_e                 op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [CNT_W-1:0]    cnt;
  logic                neg_q;
  logic                neg_r;
  logic                div_zero;
  logic                is_signed;
  logic                is_div;
  logic                op_ok;
  logic                accept;
  logic [DATA_W-1:0]   core_hi;
  logic [DATA_W-1:0]   core_lo;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;
  logic [2*DATA_W-1:0] result;

  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];

`ifdef MULDIV_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[1];
`endif

  assign accept = (state == IDLE) && start && !cancel && op_ok;

  muldiv_core u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (state == PREP),
    .step   (state == CALC),
    .is_div (is_div),
    .mag_a  (mag(a_q, is_signed)),
    .mag_b  (mag(b_q, is_signed)),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // Sign fix; a zero divisor keeps the all-ones quotient regardless of signs.
  always_comb begin
    prod   = {core_hi, core_lo};
    q_fix  = (neg_q && !div_zero) ? DATA_W'(-core_lo) : core_lo;
    r_fix  = neg_r ? DATA_W'(-core_hi) : core_hi;
    result = is_div ? {r_fix, q_fix} : (neg_q ? (2*DATA_W)'(-prod) : prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      multWe   <= 1'b0;
      busmult  <= '0;
      cnt      <= '0;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      multWe <= 1'b0;
      if (cancel && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              op_q  <= op_e'(op);
              a_q   <= a;
              b_q   <= b;
              busy  <= 1'b1;
              state <= PREP;
            end
          end
          PREP: begin
            neg_q    <= is_signed & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
            neg_r    <= is_signed & a_q[DATA_W-1];
            div_zero <= (b_q == '0);
            cnt      <= '0;
            state    <= CALC;
          end
          CALC: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(ITER_COUNT - 1)) state <= FIX;
          end
          FIX: begin
            busmult <= result;
            multWe  <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector scoreboard bench for muldiv_unit.
// Stimulus pushes {expected busmult, due cycle}; a negedge monitor pops on
// every multWe and checks value and latency. Divide vectors run when
// MULDIV_DIV_EN is defined, otherwise DIV/DIVU starts must be ignored.
module tb_muldiv_unit;

  typedef struct {
    logic [63:0] val;
    int          due;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        multWe;
  logic [63:0] busmult;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;

  muldiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .cancel  (cancel),
    .busy    (busy),
    .multWe  (multWe),
    .busmult (busmult)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every multWe cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (multWe === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_multWe: got busmult %h at cycle %0d, expected no strobe", busmult, cyc);
      end else begin
        mon_e = sb.pop_front();
        check64($sformatf("result_%0d", mon_e.tag), busmult, mon_e.val);
        check_int($sformatf("latency_%0d", mon_e.tag), cyc, mon_e.due);
      end
    end
  end

  // Drive a start; returns the cycle index of the accept edge.
  task automatic issue(input bit wait_neg, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int e0);
    if (wait_neg) @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic expect_result(input int tag, input logic [63:0] val, input int e0);
    exp_t e;
    e.val = val; e.due = e0 + 34; e.tag = tag;
    sb.push_back(e);
  endtask

  // Follow an accepted op to completion, checking busy every cycle.
  task automatic track(input int tag, input int e0);
    int k;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      k = cyc - e0;
      check_int($sformatf("busy_%0d_k%0d", tag, k), int'(busy), (k >= 0 && k <= 33) ? 1 : 0);
      if (k >= 35) break;
    end
    #1;
    check_int($sformatf("drained_%0d", tag), sb.size(), 0);
  endtask

  task automatic run_op(input int tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] val);
    int e0;
    issue(1'b1, o, x, y, e0);
    expect_result(tag, val, e0);
    track(tag, e0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish by 500us, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;

    // Reset values.
    #1;
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_multWe", int'(multWe), 0);
    check64("rst_busmult", busmult, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Signed multiply with timing checks.
    run_op(1, 2'b00, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);

    // Cancel on the 10th CALC cycle, then restart on the following edge.
    issue(1'b1, 2'b01, 32'd3, 32'd4, e0);
    repeat (11) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    check_int("cancel_busy", int'(busy), 0);
    check64("cancel_busmult_held", busmult, 64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk);
    cancel = 1'b0;
    check_int("cancel_busy_idle", int'(busy), 0);
    issue(1'b0, 2'b01, 32'd3, 32'd4, e0);
    expect_result(2, 64'd12, e0);
    track(2, e0);

    // A start while busy must be ignored.
    issue(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e0);
    expect_result(3, 64'hFFFF_FFFE_0000_0001, e0);
    repeat (6) @(negedge clk);
    op = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    track(3, e0);

    run_op(4, 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    run_op(5, 2'b01, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

    // Reset mid-CALC clears outputs immediately; first edge after release accepts.
    issue(1'b1, 2'b00, 32'd5, 32'd5, e0);
    repeat (16) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_int("midrst_busy", int'(busy), 0);
    check_int("midrst_multWe", int'(multWe), 0);
    check64("midrst_busmult", busmult, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e0);
    expect_result(6, 64'h1, e0);
    track(6, e0);

`ifdef MULDIV_DIV_EN
    run_op(10, 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(11, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_op(12, 2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
    run_op(13, 2'b11, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op(14, 2'b10, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
    run_op(15, 2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    run_op(16, 2'b11, 32'hFFFF_FFFF, 32'h0001_0000, {32'h0000_FFFF, 32'h0000_FFFF});
`else
    // Divider compiled out: DIVU start is ignored.
    issue(1'b1, 2'b11, 32'd5, 32'd0, e0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_int($sformatf("nodiv_busy_%0d", i), int'(busy), 0);
    end
    check64("nodiv_busmult_held", busmult, 64'h1);
    run_op(20, 2'b00, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
`endif

    repeat (3) @(negedge clk);
    #1;
    check_int("final_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
- clk  in  1: clock.
- rst  in  1: reset.
REQ-002 The remaining ports SHALL be:
- start  in  1: operation request, sampled on posedge clk.
- op  in  2: operation code; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32: operand A (rs value / dividend).
- b  in  32: operand B (rt value / divisor).
- cancel  in  1: pipeline flush; abandons the in-flight operation.
- busy  out  1: operation in progress.
- multWe  out  1: HI/LO write strobe, one full clk cycle.
- busmult  out  64: result, {HI, LO}.

Function
REQ-003 The state machine SHALL have states IDLE, PREP, CALC, FIX, DONE; all logic SHALL be posedge clk.
REQ-004 In IDLE with start=1 and cancel=0, the block SHALL latch a, b and op and enter PREP; start in any other state SHALL be ignored.
REQ-005 PREP SHALL form operand magnitudes (signed ops only), record result signs, clear the iteration counter, and enter CALC after one cycle.
REQ-006 CALC SHALL perform exactly 32 iterations, one per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide; after the 32nd it SHALL enter FIX.
REQ-007 FIX SHALL apply signs and load busmult, then enter DONE.
- Signed multiply: negate the 64-bit product if sign(a) XOR sign(b).
- Signed divide: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-008 In DONE, multWe SHALL be 1 for exactly that cycle; the next edge SHALL return to IDLE.
REQ-009 The accept edge is E0; multWe SHALL be high between E34 and E35 (fixed 35-cycle latency), so a negedge-clocked HI/LO register samples it once.
REQ-010 For divide results, busmult[63:32] SHALL be the remainder and busmult[31:0] the quotient; for multiply, busmult SHALL be the full 64-bit product.
REQ-011 Divide by zero SHALL give remainder = a and quotient = 32'hFFFFFFFF, with the same 35-cycle latency.
REQ-012 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give quotient 32'h80000000 and remainder 0, with no special-case trap.
REQ-013 busy SHALL be 1 in PREP, CALC and FIX, and 0 in IDLE and DONE.
REQ-014 busmult SHALL hold its last value until the next FIX.
REQ-015 cancel=1 in any state other than IDLE SHALL force IDLE at the next edge, with no multWe pulse and busmult unchanged.
REQ-016 cancel=1 together with start=1 in IDLE SHALL not start an operation (cancel wins).

Reset
REQ-017 rst SHALL immediately force state IDLE, busy=0, multWe=0, busmult=0, counter=0, and discard any operation in flight.
REQ-018 After rst deasserts, the first posedge SHALL be able to accept start.

Configuration
REQ-019 The macro MULDIV_DIV_EN SHALL compile the divider datapath in.
- Defined: DIV and DIVU operate as specified above.
- Undefined: start with op=DIV or op=DIVU SHALL be ignored in IDLE (no state change, busy=0, no multWe); multiply behaviour and latency SHALL be unchanged.

Structure
REQ-020 Package muldiv_pkg SHALL hold the op encodings, the state enumeration, the iteration count constant (32) and the divide-by-zero quotient constant.
REQ-021 One sub-module, muldiv_core, SHALL hold the iteration datapath (accumulator, shift register, adder/subtractor); muldiv_unit SHALL hold the FSM, counter, sign fix and handshake.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- MULT a=32'hFFFFFFFE, b=3 -> busmult=64'hFFFFFFFF_FFFFFFFA; multWe high exactly in cycle E34..E35; busy high E0+ to E34.
- MULTU a=b=32'hFFFFFFFF -> busmult=64'hFFFFFFFE_00000001.
- DIV a=-7 (32'hFFFFFFF9), b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIV 32'h80000000/32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- DIVU a=5, b=0 -> HI=5, LO=32'hFFFFFFFF at 35-cycle latency; without MULDIV_DIV_EN, the same start -> busy stays 0 and no multWe.
- cancel on the 10th CALC cycle -> IDLE next edge, no multWe, busmult unchanged; a start on the following edge is accepted and completes normally.
- rst asserted mid-CALC -> outputs 0 immediately; a start while busy=1 is ignored (result matches the first operation only).
